// File: rtl/hidden_layer_mac_pkg.sv
// Shared sizes, FSM encoding and product helper for the hidden layer.
// Imported by the parameter block, this MAC engine and the output layer.
package hidden_layer_mac_pkg;

    localparam int N_IN      = 784;
    localparam int N_NEURON  = 30;
    localparam int DATA_W    = 8;
    localparam int FRAC_BITS = 6;
    localparam int ACC_W     = 26;

    localparam int I_W    = $clog2(N_IN);
    localparam int N_W    = $clog2(N_NEURON);
    localparam int WIDX_W = $clog2(N_IN * N_NEURON);

    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_LOAD   = 3'd1;
    localparam logic [2:0] ENC_MAC    = 3'd2;
    localparam logic [2:0] ENC_FINISH = 3'd3;
    localparam logic [2:0] ENC_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ENC_IDLE,
        LOAD   = ENC_LOAD,
        MAC    = ENC_MAC,
        FINISH = ENC_FINISH,
        DONE   = ENC_DONE
    } state_e;

    // Signed weight x pixel product, sign-extended to accumulator width.
    function automatic logic signed [ACC_W-1:0] mac_prod(
        input logic signed [DATA_W-1:0] w,
        input logic signed [DATA_W-1:0] x
    );
        logic signed [2*DATA_W-1:0] p;
        p = w * x;
        return {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
    endfunction

endpackage

// File: rtl/hl_relu_sat.sv
// Bias add, fixed-point rescale and clamp of one accumulator value.
// RELU=0 clamps to the full signed range for the output layer.
module hl_relu_sat
    import hidden_layer_mac_pkg::*;
#(
    parameter bit RELU = 1'b1
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic signed [DATA_W-1:0] bias_i,
    output logic        [DATA_W-1:0] act_o
);

    localparam int MAX_I = 2 ** (DATA_W - 1) - 1;
    localparam int MIN_I = RELU ? 0 : -(2 ** (DATA_W - 1));

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(MAX_I);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(MIN_I);

    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shr;

    // Align bias to the product scale, drop fraction (toward -inf), clamp.
    always_comb begin
        bias_ext = {{(ACC_W-DATA_W){bias_i[DATA_W-1]}}, bias_i};
        sum      = acc_i + (bias_ext <<< FRAC_BITS);
        shr      = sum >>> FRAC_BITS;
        if (shr < MIN_V) begin
            act_o = MIN_V[DATA_W-1:0];
        end else if (shr > MAX_V) begin
            act_o = MAX_V[DATA_W-1:0];
        end else begin
            act_o = shr[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/hidden_layer_mac.sv
// Hidden-layer engine: one time-shared MAC walks all neurons in turn.
// Each neuron takes N_IN MAC cycles plus one finish cycle.
module hidden_layer_mac
    import hidden_layer_mac_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [DATA_W*N_IN-1:0]       pixels_in,
    input  logic [DATA_W*N_NEURON*N_IN-1:0] weights_HL,
    input  logic [DATA_W*N_NEURON-1:0]   biases_HL,
    output logic                         busy,
    output logic                         done,
    output logic [DATA_W*N_NEURON-1:0]   act_out
);

    state_e                    state_q, state_d;
    logic [DATA_W*N_IN-1:0]    pix_q, pix_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [N_W-1:0]            n_q, n_d;
    logic [I_W-1:0]            i_q, i_d;
    logic [DATA_W*N_NEURON-1:0] act_q, act_d;

    logic [WIDX_W-1:0]         w_idx;
    int                        w_off;
    int                        x_off;
    int                        b_off;
    logic signed [DATA_W-1:0]  w_cur;
    logic signed [DATA_W-1:0]  x_cur;
    logic signed [DATA_W-1:0]  b_cur;
    logic [DATA_W-1:0]         act_val;

    // Select the operands addressed by the neuron and input counters.
    always_comb begin
        w_idx = WIDX_W'(n_q) * WIDX_W'(N_IN) + WIDX_W'(i_q);
        w_off = int'(w_idx) * DATA_W;
        x_off = int'(i_q) * DATA_W;
        b_off = int'(n_q) * DATA_W;
        w_cur = weights_HL[w_off +: DATA_W];
        x_cur = pix_q[x_off +: DATA_W];
        b_cur = biases_HL[b_off +: DATA_W];
    end

    hl_relu_sat #(
        .RELU (1'b1)
    ) u_relu_sat (
        .acc_i  (acc_q),
        .bias_i (b_cur),
        .act_o  (act_val)
    );

    // Next-state, datapath updates and status outputs.
    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        acc_d   = acc_q;
        n_d     = n_q;
        i_d     = i_q;
        act_d   = act_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pix_d   = pixels_in;
                acc_d   = '0;
                n_d     = '0;
                i_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d = acc_q + mac_prod(w_cur, x_cur);
                if (i_q == I_W'(N_IN - 1)) begin
                    i_d     = '0;
                    state_d = FINISH;
                end else begin
                    i_d = i_q + I_W'(1);
                end
            end
            FINISH: begin
                act_d[b_off +: DATA_W] = act_val;
                acc_d = '0;
                if (n_q == N_W'(N_NEURON - 1)) begin
                    state_d = DONE;
                end else begin
                    n_d     = n_q + N_W'(1);
                    state_d = MAC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        act_out = act_q;
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pix_q   <= '0;
            acc_q   <= '0;
            n_q     <= '0;
            i_q     <= '0;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            i_q     <= i_d;
            act_q   <= act_d;
        end
    end

endmodule
